// File: rtl/lcd_value_writer_pkg.sv
// Shared definitions for the LCD value writer: HD44780 command bytes,
// sequencer and nibble-transmitter state encodings, and the BCD helper.
package lcd_value_writer_pkg;

    localparam int CNT_W = 20;

    // HD44780 command and character constants
    localparam logic [7:0] FUNC_SET = 8'h28;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] DDRAM_L1 = 8'h80;
    localparam logic [7:0] ASCII_0  = 8'h30;

    // Sequencer states
    localparam logic [2:0] ST_PWRON = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_CFG   = 3'd2;
    localparam logic [2:0] ST_CLRW  = 3'd3;
    localparam logic [2:0] ST_IDLE  = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;

    // Nibble transmitter states
    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_SETUP = 3'd1;
    localparam logic [2:0] TX_HIGH  = 3'd2;
    localparam logic [2:0] TX_HOLD  = 3'd3;
    localparam logic [2:0] TX_WAIT  = 3'd4;

    // Double-dabble: 8-bit binary to {hundreds, tens, ones} BCD
    function automatic logic [11:0] to_bcd(input logic [7:0] bin);
        logic [19:0] s;
        s = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (s[11:8] >= 4'd5) s[11:8] = s[11:8] + 4'd3;
            if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
            if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
            s = s << 1;
        end
        return s[19:8];
    endfunction

endpackage

// File: rtl/lcd_value_writer_nibble_tx.sv
// Sends one 4-bit nibble to the LCD: data/rs setup, enable pulse, one
// cycle of hold, then a caller-chosen wait before signalling done.
module lcd_value_writer_nibble_tx
    import lcd_value_writer_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       nib,
    input  logic             reg_sel,
    input  logic [CNT_W-1:0] wait_cyc,
    output logic [3:0]       lcd_d,
    output logic             lcd_e,
    output logic             lcd_rs,
    output logic             done
);

    localparam logic [CNT_W-1:0] SETUP_V = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] E_V     = CNT_W'(E_CYC);

    logic [2:0]       st_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] wait_r;

    // Nibble timing: data and rs only change in TX_IDLE, so lcd_e never overlaps a change
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r   <= TX_IDLE;
            cnt_r  <= '0;
            wait_r <= '0;
            lcd_d  <= 4'h0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st_r)
                TX_IDLE: begin
                    if (start) begin
                        lcd_d  <= nib;
                        lcd_rs <= reg_sel;
                        wait_r <= wait_cyc;
                        cnt_r  <= SETUP_V - 20'd1;
                        st_r   <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    if (cnt_r == 20'd0) begin
                        lcd_e <= 1'b1;
                        cnt_r <= E_V - 20'd1;
                        st_r  <= TX_HIGH;
                    end else begin
                        cnt_r <= cnt_r - 20'd1;
                    end
                end
                TX_HIGH: begin
                    if (cnt_r == 20'd0) begin
                        lcd_e <= 1'b0;
                        st_r  <= TX_HOLD;
                    end else begin
                        cnt_r <= cnt_r - 20'd1;
                    end
                end
                TX_HOLD: begin
                    cnt_r <= wait_r - 20'd1;
                    st_r  <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (cnt_r == 20'd0) begin
                        done <= 1'b1;
                        st_r <= TX_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 20'd1;
                    end
                end
                default: begin
                    lcd_e <= 1'b0;
                    st_r  <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_value_writer.sv
// Displays an 8-bit count as three decimal digits at line 1, column 0 of an
// HD44780 character LCD in 4-bit mode. Runs power-on init once, then
// rewrites the digits whenever the input differs from what is shown.
module lcd_value_writer
    import lcd_value_writer_pkg::*;
#(
    parameter int PWRON_CYC = 750000,
    parameter int W4100_CYC = 205000,
    parameter int W100_CYC  = 5000,
    parameter int W40_CYC   = 2000,
    parameter int W1640_CYC = 82000,
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 12,
    parameter int GAP_CYC   = 50
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [7:0] value,
    output logic [3:0] lcd_d,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       busy
);

    localparam logic [CNT_W-1:0] PWRON_V = CNT_W'(PWRON_CYC);
    localparam logic [CNT_W-1:0] W4100_V = CNT_W'(W4100_CYC);
    localparam logic [CNT_W-1:0] W100_V  = CNT_W'(W100_CYC);
    localparam logic [CNT_W-1:0] W40_V   = CNT_W'(W40_CYC);
    localparam logic [CNT_W-1:0] W1640_V = CNT_W'(W1640_CYC);
    localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(GAP_CYC);

    logic [2:0]       state_r;
    logic [1:0]       idx_r;
    logic             lo_r, pend_r, armed_r, dirty_r, busy_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [7:0]       shown_r;
    logic [11:0]      digits_r;
    logic             start_r, tx_rs_r, tx_done;
    logic [3:0]       tx_nib_r;
    logic [CNT_W-1:0] tx_wait_r;

    logic             item_byte, item_rs;
    logic [7:0]       item_val;
    logic [CNT_W-1:0] item_wait;
    logic [3:0]       nib_sel;
    logic [CNT_W-1:0] wait_sel;

    assign lcd_rw = 1'b0;
    assign busy   = busy_r;

    // Current item of the active sequence, and which nibble/wait to send next
    always_comb begin
        item_byte = 1'b1;
        item_rs   = 1'b0;
        item_val  = 8'h00;
        item_wait = W40_V;
        case (state_r)
            ST_INIT: begin
                item_byte = 1'b0;
                if (idx_r == 2'd3) begin
                    item_val = 8'h02;
                end else begin
                    item_val = 8'h03;
                end
                if (idx_r == 2'd0) begin
                    item_wait = W4100_V;
                end else if (idx_r == 2'd3) begin
                    item_wait = W40_V;
                end else begin
                    item_wait = W100_V;
                end
            end
            ST_CFG: begin
                case (idx_r)
                    2'd0:    item_val = FUNC_SET;
                    2'd1:    item_val = ENTRY;
                    2'd2:    item_val = DISP_ON;
                    default: item_val = CLEAR;
                endcase
            end
            ST_WRITE: begin
                case (idx_r)
                    2'd0: item_val = DDRAM_L1;
                    2'd1: begin
                        item_rs  = 1'b1;
                        item_val = ASCII_0 + {4'h0, digits_r[11:8]};
                    end
                    2'd2: begin
                        item_rs  = 1'b1;
                        item_val = ASCII_0 + {4'h0, digits_r[7:4]};
                    end
                    default: begin
                        item_rs  = 1'b1;
                        item_val = ASCII_0 + {4'h0, digits_r[3:0]};
                    end
                endcase
            end
            default: begin
                item_byte = 1'b0;
            end
        endcase
        if (item_byte && !lo_r) begin
            nib_sel  = item_val[7:4];
            wait_sel = GAP_V;
        end else begin
            nib_sel  = item_val[3:0];
            wait_sel = item_wait;
        end
    end

    // Sequencer: power-on wait, init nibbles, config bytes, then idle/write loop
    always_ff @(posedge clk) begin
        if (rs) begin
            state_r    <= ST_PWRON;
            idx_r      <= 2'd0;
            lo_r       <= 1'b0;
            pend_r     <= 1'b0;
            armed_r    <= 1'b0;
            dirty_r    <= 1'b1;
            busy_r     <= 1'b1;
            wait_cnt_r <= '0;
            shown_r    <= 8'h00;
            digits_r   <= 12'h000;
            start_r    <= 1'b0;
            tx_nib_r   <= 4'h0;
            tx_rs_r    <= 1'b0;
            tx_wait_r  <= '0;
        end else begin
            start_r <= 1'b0;
            case (state_r)
                ST_PWRON, ST_CLRW: begin
                    if (!armed_r) begin
                        wait_cnt_r <= (state_r == ST_PWRON) ? PWRON_V - 20'd1 : W1640_V - 20'd1;
                        armed_r    <= 1'b1;
                    end else if (wait_cnt_r == 20'd0) begin
                        armed_r <= 1'b0;
                        idx_r   <= 2'd0;
                        if (state_r == ST_PWRON) begin
                            state_r <= ST_INIT;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 20'd1;
                    end
                end
                ST_INIT, ST_CFG, ST_WRITE: begin
                    if (!pend_r) begin
                        start_r   <= 1'b1;
                        tx_nib_r  <= nib_sel;
                        tx_rs_r   <= item_rs;
                        tx_wait_r <= wait_sel;
                        pend_r    <= 1'b1;
                    end else if (tx_done) begin
                        pend_r <= 1'b0;
                        if (item_byte && !lo_r) begin
                            lo_r <= 1'b1;
                        end else begin
                            lo_r <= 1'b0;
                            if (idx_r == 2'd3) begin
                                idx_r <= 2'd0;
                                case (state_r)
                                    ST_INIT: state_r <= ST_CFG;
                                    ST_CFG: begin
                                        state_r <= ST_CLRW;
                                        armed_r <= 1'b0;
                                    end
                                    default: begin
                                        state_r <= ST_IDLE;
                                        busy_r  <= 1'b0;
                                    end
                                endcase
                            end else begin
                                idx_r <= idx_r + 2'd1;
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    // Snapshot once so all three digits come from the same value
                    if (dirty_r || (value != shown_r)) begin
                        shown_r  <= value;
                        digits_r <= to_bcd(value);
                        dirty_r  <= 1'b0;
                        idx_r    <= 2'd0;
                        state_r  <= ST_WRITE;
                        busy_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_PWRON;
                    armed_r <= 1'b0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    lcd_value_writer_nibble_tx #(
        .SETUP_CYC(SETUP_CYC),
        .E_CYC    (E_CYC)
    ) u_tx (
        .clk     (clk),
        .rst     (rs),
        .start   (start_r),
        .nib     (tx_nib_r),
        .reg_sel (tx_rs_r),
        .wait_cyc(tx_wait_r),
        .lcd_d   (lcd_d),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_lcd_value_writer.sv
// Directed bench for lcd_value_writer with scaled timing parameters.
module tb_lcd_value_writer;

    localparam int SETUP = 2;
    localparam int ECYC  = 3;

    logic       clk = 1'b0;
    logic       rs;
    logic [7:0] value;
    logic [3:0] lcd_d;
    logic       lcd_e, lcd_rs, lcd_rw, busy;

    int errors = 0;
    int checks = 0;

    logic [4:0] pulses[$];
    bit         mon_off = 1'b1;

    lcd_value_writer #(
        .PWRON_CYC(20), .W4100_CYC(10), .W100_CYC(5), .W40_CYC(4),
        .W1640_CYC(8), .SETUP_CYC(SETUP), .E_CYC(ECYC), .GAP_CYC(2)
    ) dut (
        .clk(clk), .rs(rs), .value(value), .lcd_d(lcd_d), .lcd_e(lcd_e),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: records {rs, d} at each lcd_e rise and checks strobe timing
    logic [4:0] prev_dr, cur, hold_val;
    logic       prev_e;
    int         stable, high_cnt;
    bit         hold_pend;
    always @(negedge clk) begin
        cur = {lcd_rs, lcd_d};
        if (mon_off) begin
            prev_e    = lcd_e;
            prev_dr   = cur;
            stable    = 0;
            high_cnt  = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_after_e", {27'd0, cur}, {27'd0, hold_val});
                hold_pend = 1'b0;
            end
            if (cur != prev_dr) stable = 1;
            else stable++;
            if (lcd_e && !prev_e) begin
                check("setup_ok", {31'd0, (stable - 1) >= SETUP}, 32'd1);
                pulses.push_back(cur);
                high_cnt = 1;
            end else if (lcd_e && prev_e) begin
                check("e_data_stable", {27'd0, cur}, {27'd0, prev_dr});
                high_cnt++;
            end else if (!lcd_e && prev_e) begin
                check("e_width", high_cnt, ECYC);
                check("fall_data", {27'd0, cur}, {27'd0, prev_dr});
                hold_pend = 1'b1;
                hold_val  = cur;
            end
            prev_e  = lcd_e;
            prev_dr = cur;
        end
    end

    task automatic exp_nib(input string tag, input logic r, input logic [3:0] n);
        int k;
        logic [4:0] p;
        k = 0;
        while (pulses.size() == 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (pulses.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            p = pulses.pop_front();
            check(tag, {27'd0, p}, {27'd0, r, n});
        end
    endtask

    task automatic exp_byte(input string tag, input logic r, input logic [7:0] b);
        exp_nib(tag, r, b[7:4]);
        exp_nib(tag, r, b[3:0]);
    endtask

    task automatic exp_init();
        exp_nib("init0", 1'b0, 4'h3);
        exp_nib("init1", 1'b0, 4'h3);
        exp_nib("init2", 1'b0, 4'h3);
        exp_nib("init3", 1'b0, 4'h2);
        exp_byte("func_set", 1'b0, 8'h28);
        exp_byte("entry", 1'b0, 8'h06);
        exp_byte("disp_on", 1'b0, 8'h0C);
        exp_byte("clear", 1'b0, 8'h01);
    endtask

    task automatic exp_write(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2);
        exp_byte({tag, "_addr"}, 1'b0, 8'h80);
        exp_byte({tag, "_d0"}, 1'b1, c0);
        exp_byte({tag, "_d1"}, 1'b1, c1);
        exp_byte({tag, "_d2"}, 1'b1, c2);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic quiet(input string tag);
        repeat (60) @(negedge clk);
        check({tag, "_no_pulses"}, pulses.size(), 32'd0);
        check({tag, "_still_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rs    = 1'b1;
        value = 8'd0;
        // 1: reset then power-on init and "000"
        repeat (3) @(negedge clk);
        check("rst_e", {31'd0, lcd_e}, 32'd0);
        check("rst_d", {28'd0, lcd_d}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_rw", {31'd0, lcd_rw}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        rs      = 1'b0;
        mon_off = 1'b0;
        exp_init();
        check("busy_in_init", {31'd0, busy}, 32'd1);
        exp_write("w000", 8'h30, 8'h30, 8'h30);
        wait_idle("t1");
        quiet("t1");

        // 2: value 255
        value = 8'd255;
        repeat (2) @(negedge clk);
        check("t2_busy_high", {31'd0, busy}, 32'd1);
        exp_write("w255", 8'h32, 8'h35, 8'h35);
        wait_idle("t2");

        // 3: 7 -> 42 during the second data byte of "007"
        value = 8'd7;
        exp_byte("w007_addr", 1'b0, 8'h80);
        exp_byte("w007_d0", 1'b1, 8'h30);
        exp_nib("w007_d1", 1'b1, 4'h3);
        value = 8'd42;
        exp_nib("w007_d1", 1'b1, 4'h0);
        exp_byte("w007_d2", 1'b1, 8'h37);
        exp_write("w042", 8'h30, 8'h34, 8'h32);
        wait_idle("t3");

        // 6: 5 -> 6 -> 5 within one write of "005"
        value = 8'd5;
        exp_byte("w005_addr", 1'b0, 8'h80);
        value = 8'd6;
        exp_byte("w005_d0", 1'b1, 8'h30);
        value = 8'd5;
        exp_byte("w005_d1", 1'b1, 8'h30);
        exp_byte("w005_d2", 1'b1, 8'h35);
        wait_idle("t6");
        quiet("t6");

        // 5: reset pulse mid-write restarts full init
        value = 8'd100;
        exp_byte("w100a_addr", 1'b0, 8'h80);
        exp_nib("w100a_d0", 1'b1, 4'h3);
        @(negedge clk);
        mon_off = 1'b1;
        rs      = 1'b1;
        @(negedge clk);
        check("t5_e_low", {31'd0, lcd_e}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd1);
        rs = 1'b0;
        @(negedge clk);
        pulses.delete();
        mon_off = 1'b0;
        exp_init();
        exp_write("w100", 8'h31, 8'h30, 8'h30);
        wait_idle("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
